pipe_hazard_ctrl: RTL and testbench

// - Sequencing controller for the 5-stage pipeline (IF/ID/EX/MEM/WB) around InstDecode.
// - Generates PC/IF-ID enables, bubble/flush controls and operand-forwarding selects.
// - Runs the HALT drain, and keeps saturating stall/flush counters for debug.
// - Consumes decoded fields from ID plus register-write info from EX and WB.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 7 +
 rtl/pipe_hazard_ctrl_hazard_fwd_unit.sv | 33 +++
 rtl/pipe_hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared opcode, mem-mode, FSM state and forwarding encodings.
package pipe_hazard_ctrl_pkg;
    localparam logic [6:0] OP_HALT = 7'h7F;
    localparam logic [1:0] MD_LD   = 2'b01;
    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_DRAIN, ST_HALTED} state_e;
    typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_EX = 2'b01, FWD_WB = 2'b10} fwd_e;
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_fwd_unit.sv
// hazard_fwd_unit: combinational load-use detection and operand forwarding selects.
module hazard_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter bit R0_ZERO = 1'b1
) (
    input  logic [4:0] id_sa,
    input  logic [4:0] id_sb,
    input  logic       id_ma,
    input  logic       id_mb,
    input  logic       ex_valid,
    input  logic       ex_rw,
    input  logic [1:0] ex_md,
    input  logic [4:0] ex_dr,
    input  logic       wb_valid,
    input  logic       wb_rw,
    input  logic [4:0] wb_dr,
    output logic       load_use,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);
    logic ex_ld, ex_alu, wb_w, a_live, b_live;
    always_comb begin
        ex_ld    = ex_valid & ex_rw & (ex_md == MD_LD);
        ex_alu   = ex_valid & ex_rw & (ex_md != MD_LD);
        wb_w     = wb_valid & wb_rw;
        a_live   = !(R0_ZERO && id_sa == 5'd0);
        b_live   = !(R0_ZERO && id_sb == 5'd0);
        load_use = ex_ld & ((!id_ma & a_live & (ex_dr == id_sa)) | (!id_mb & b_live & (ex_dr == id_sb)));
        fwd_a    = !a_live ? FWD_RF : (ex_alu && ex_dr == id_sa) ? FWD_EX : (wb_w && wb_dr == id_sa) ? FWD_WB : FWD_RF;
        fwd_b    = !b_live ? FWD_RF : (ex_alu && ex_dr == id_sb) ? FWD_EX : (wb_w && wb_dr == id_sb) ? FWD_WB : FWD_RF;
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline sequencing (stall/flush/halt drain) with perf counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter bit R0_ZERO      = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_sa,
    input  logic [4:0]       id_sb,
    input  logic             id_ma,
    input  logic             id_mb,
    input  logic             ex_valid,
    input  logic             ex_rw,
    input  logic [1:0]       ex_md,
    input  logic [4:0]       ex_dr,
    input  logic             wb_valid,
    input  logic             wb_rw,
    input  logic [4:0]       wb_dr,
    input  logic             ex_br_taken,
    input  logic             imem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int DW = DRAIN_CYCLES > 2 ? $clog2(DRAIN_CYCLES) : 1;
    state_e         state_q, state_d;
    logic [DW-1:0]  drain_q, drain_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
    logic           load_use;
    logic [1:0]     fwd_a_raw, fwd_b_raw;
    logic           pc_en_n, if_id_en_n, if_id_flush_n, id_ex_flush_n;

    hazard_fwd_unit #(.R0_ZERO(R0_ZERO)) u_hfu (
        .id_sa(id_sa), .id_sb(id_sb), .id_ma(id_ma), .id_mb(id_mb),
        .ex_valid(ex_valid), .ex_rw(ex_rw), .ex_md(ex_md), .ex_dr(ex_dr),
        .wb_valid(wb_valid), .wb_rw(wb_rw), .wb_dr(wb_dr),
        .load_use(load_use), .fwd_a(fwd_a_raw), .fwd_b(fwd_b_raw)
    );

    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        stall_d       = stall_q;
        flush_d       = flush_q;
        pc_en_n       = imem_ready;
        if_id_en_n    = 1'b1;
        if_id_flush_n = !imem_ready;
        id_ex_flush_n = 1'b0;
        case (state_q)
            ST_RUN: begin
                // taken branch discards wrong-path stall or HALT in ID
                if (ex_br_taken) begin
                    pc_en_n       = 1'b1;
                    if_id_flush_n = 1'b1;
                    id_ex_flush_n = 1'b1;
                    state_d       = ST_FLUSH;
                    flush_d       = &flush_q ? flush_q : flush_q + CNT_W'(1);
                end else if (load_use) begin
                    pc_en_n       = 1'b0;
                    if_id_en_n    = 1'b0;
                    if_id_flush_n = 1'b0;
                    id_ex_flush_n = 1'b1;
                    stall_d       = &stall_q ? stall_q : stall_q + CNT_W'(1);
                end else if (id_valid && id_opcode == OP_HALT) begin
                    pc_en_n       = 1'b0;
                    if_id_flush_n = 1'b1;
                    state_d       = ST_DRAIN;
                    drain_d       = DW'(DRAIN_CYCLES - 1);
                end
            end
            ST_FLUSH: state_d = ST_RUN;
            ST_DRAIN: begin
                pc_en_n       = 1'b0;
                if_id_flush_n = 1'b1;
                state_d       = drain_q == '0 ? ST_HALTED : ST_DRAIN;
                drain_d       = drain_q == '0 ? drain_q : drain_q - DW'(1);
            end
            default: begin
                pc_en_n       = 1'b0;
                if_id_en_n    = 1'b0;
                if_id_flush_n = 1'b1;
                id_ex_flush_n = 1'b1;
            end
        endcase
        pc_en       = !rst & pc_en_n;
        if_id_en    = !rst & if_id_en_n;
        if_id_flush = rst | if_id_flush_n;
        id_ex_flush = rst | id_ex_flush_n;
        fwd_a       = rst ? FWD_RF : fwd_a_raw;
        fwd_b       = rst ? FWD_RF : fwd_b_raw;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            drain_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign halted    = state_q == ST_HALTED;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random stimulus against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;
    localparam int DRAIN = 3;
    localparam int CMAX  = 65535;

    logic clk = 1'b0, rst = 1'b1;
    logic id_valid, id_ma, id_mb, ex_valid, ex_rw, wb_valid, wb_rw, ex_br_taken, imem_ready;
    logic [6:0] id_opcode;
    logic [4:0] id_sa, id_sb, ex_dr, wb_dr;
    logic [1:0] ex_md, fwd_a, fwd_b;
    logic pc_en, if_id_en, if_id_flush, id_ex_flush, halted;
    logic [15:0] stall_cnt, flush_cnt;

    int n_chk = 0, n_fail = 0;
    int m_edges, m_stall, m_flush;
    bit m_after_br;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .R0_ZERO(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_sa(id_sa), .id_sb(id_sb), .id_ma(id_ma), .id_mb(id_mb),
        .ex_valid(ex_valid), .ex_rw(ex_rw), .ex_md(ex_md), .ex_dr(ex_dr),
        .wb_valid(wb_valid), .wb_rw(wb_rw), .wb_dr(wb_dr),
        .ex_br_taken(ex_br_taken), .imem_ready(imem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (src == 5'd0) return 2'd0;
        if (ex_valid && ex_rw && ex_md != 2'b01 && ex_dr == src) return 2'd1;
        if (wb_valid && wb_rw && wb_dr == src) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit ref_lu();
        bit a = !id_ma && id_sa != 5'd0 && id_sa == ex_dr;
        bit b = !id_mb && id_sb != 5'd0 && id_sb == ex_dr;
        return ex_valid && ex_rw && ex_md == 2'b01 && (a || b);
    endfunction

    function automatic bit ref_halt_in_id();
        return id_valid && id_opcode == OP_HALT;
    endfunction

    task automatic model_reset();
        m_edges = 0; m_stall = 0; m_flush = 0; m_after_br = 1'b0;
    endtask

    task automatic model_edge();
        if (m_edges > 0) m_edges++;
        else if (m_after_br) m_after_br = 1'b0;
        else if (ex_br_taken) begin m_after_br = 1'b1; m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX; end
        else if (ref_lu()) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        else if (ref_halt_in_id()) m_edges = 1;
    endtask

    task automatic check_outs();
        logic [3:0] e;
        logic [1:0] ea, eb;
        ea = rst ? 2'd0 : ref_fwd(id_sa);
        eb = rst ? 2'd0 : ref_fwd(id_sb);
        if (rst || m_edges > DRAIN) e = 4'b0011;
        else if (m_edges > 0) e = 4'b0110;
        else if (!m_after_br && ex_br_taken) e = 4'b1111;
        else if (!m_after_br && ref_lu()) e = 4'b0001;
        else if (!m_after_br && ref_halt_in_id()) e = 4'b0110;
        else e = {imem_ready, 1'b1, !imem_ready, 1'b0};
        chk("pc_en", 32'(pc_en), 32'(e[3]));
        chk("if_id_en", 32'(if_id_en), 32'(e[2]));
        chk("if_id_flush", 32'(if_id_flush), 32'(e[1]));
        chk("id_ex_flush", 32'(id_ex_flush), 32'(e[0]));
        chk("fwd_a", 32'(fwd_a), 32'(ea));
        chk("fwd_b", 32'(fwd_b), 32'(eb));
        chk("halted", 32'(halted), 32'(!rst && m_edges > DRAIN));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    endtask

    task automatic step(input bit do_chk);
        @(negedge clk);
        if (do_chk) check_outs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_opcode = 7'h01; id_sa = 0; id_sb = 0; id_ma = 1; id_mb = 1;
        ex_valid = 0; ex_rw = 0; ex_md = 0; ex_dr = 0;
        wb_valid = 0; wb_rw = 0; wb_dr = 0; ex_br_taken = 0; imem_ready = 1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1 check_outs();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic rand_inputs();
        id_valid    = $urandom_range(0, 3) != 0;
        id_opcode   = ($urandom_range(0, 15) == 0) ? OP_HALT : 7'($urandom);
        id_sa       = 5'($urandom_range(0, 3));
        id_sb       = 5'($urandom_range(0, 3));
        id_ma       = $urandom_range(0, 2) == 0;
        id_mb       = $urandom_range(0, 2) == 0;
        ex_valid    = $urandom_range(0, 3) != 0;
        ex_rw       = $urandom_range(0, 3) != 0;
        ex_md       = 2'($urandom_range(0, 3));
        ex_dr       = 5'($urandom_range(0, 3));
        wb_valid    = 1'($urandom);
        wb_rw       = 1'($urandom);
        wb_dr       = 5'($urandom_range(0, 3));
        ex_br_taken = $urandom_range(0, 9) == 0;
        imem_ready  = $urandom_range(0, 4) != 0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc_en", 32'(pc_en), 0);
        chk("rst_if_id_en", 32'(if_id_en), 0);
        chk("rst_flushes", {30'd0, if_id_flush, id_ex_flush}, 3);
        chk("rst_halted", 32'(halted), 0);
        rst = 1'b0;
        step(1);
        // load-use: LD r3 in EX, consumer of r3 in ID
        id_valid = 1; id_sa = 3; id_ma = 0;
        ex_valid = 1; ex_rw = 1; ex_md = 2'b01; ex_dr = 3;
        #1 chk("lu_pc_en", 32'(pc_en), 0);
        chk("lu_id_ex_flush", 32'(id_ex_flush), 1);
        step(1);
        chk("lu_stall_cnt", 32'(stall_cnt), 1);
        ex_valid = 0; wb_valid = 1; wb_rw = 1; wb_dr = 3;
        #1 chk("lu_fwd_a_wb", 32'(fwd_a), 2);
        chk("lu_resume_pc_en", 32'(pc_en), 1);
        step(1);
        // ALU result in EX forwards to B, and wins over WB
        idle_inputs();
        id_valid = 1; id_sa = 1; id_ma = 0; id_sb = 5; id_mb = 0;
        ex_valid = 1; ex_rw = 1; ex_md = 2'b00; ex_dr = 5;
        #1 chk("alu_fwd_b_ex", 32'(fwd_b), 1);
        chk("alu_no_stall", 32'(pc_en), 1);
        step(1);
        wb_valid = 1; wb_rw = 1; wb_dr = 5;
        #1 chk("alu_fwd_b_ex_over_wb", 32'(fwd_b), 1);
        step(1);
        // taken branch beats HALT in ID
        idle_inputs();
        id_valid = 1; id_opcode = OP_HALT; ex_br_taken = 1;
        #1 chk("br_if_id_flush", 32'(if_id_flush), 1);
        chk("br_id_ex_flush", 32'(id_ex_flush), 1);
        step(1);
        chk("br_flush_cnt", 32'(flush_cnt), 1);
        idle_inputs();
        step(1);
        chk("br_not_halted", 32'(halted), 0);
        // HALT drain: halted on 4th edge after decode
        id_valid = 1; id_opcode = OP_HALT;
        step(1);
        idle_inputs();
        step(1);
        step(1);
        chk("drain_halted_edge3", 32'(halted), 0);
        step(1);
        chk("drain_halted_edge4", 32'(halted), 1);
        step(1);
        // reset in the middle of DRAIN
        do_reset();
        id_valid = 1; id_opcode = OP_HALT;
        step(1);
        idle_inputs();
        step(1);
        rst = 1'b1;
        model_reset();
        #1 chk("mid_rst_pc_en", 32'(pc_en), 0);
        chk("mid_rst_if_id_flush", 32'(if_id_flush), 1);
        chk("mid_rst_id_ex_flush", 32'(id_ex_flush), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("post_rst_pc_en", 32'(pc_en), 1);
        chk("post_rst_halted", 32'(halted), 0);
        step(1);
        // register 0 never stalls or forwards
        id_valid = 1; id_sa = 0; id_ma = 0;
        ex_valid = 1; ex_rw = 1; ex_md = 2'b01; ex_dr = 0;
        #1 chk("r0_no_stall", 32'(pc_en), 1);
        chk("r0_fwd_a", 32'(fwd_a), 0);
        step(1);
        // stall counter saturation
        id_sa = 3; ex_dr = 3;
        for (int i = 0; i < 70000; i++) step(0);
        chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
        step(1);
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rand_inputs();
            step(1);
            if (m_edges > DRAIN + 2) do_reset();
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
